// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types and constants for the clock time-set controller: FSM state
// enum, edit-field codes, field widths and limits, and a wrap-around
// increment helper used when the user steps a time field.
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

   localparam int HOUR_W   = 5;
   localparam int MIN_W    = 6;
   localparam int SEC_W    = 6;

   localparam int MAX_HOUR = 23;
   localparam int MAX_MIN  = 59;
   localparam int MAX_SEC  = 59;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   // Codes presented on the field output so a display can pick what to blink.
   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   // Step a time field by one, rolling over to zero past its maximum.
   // Six bits covers the widest field; callers narrow the result.
   function automatic logic [5:0] wrap_inc(input logic [5:0] value,
                                           input logic [5:0] max_value);
      return (value == max_value) ? 6'd0 : value + 6'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider: while run is high it counts 0..DIV-1 and raises tick
// during the cycle the count sits at DIV-1, then wraps. While run is low the
// count holds at 0, so the first tick after run rises comes DIV cycles later.
// restart forces the count back to 0 without stopping it.
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-low reset
//   run      in  count enable; low holds the count at 0
//   restart  in  one-cycle request to restart the count at 0
//   tick     out high for one cycle at the end of each DIV-cycle period
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic tick
);

   localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_count;

   // NOTE: reset is sampled inside the clocked block (synchronous), and all
   // state is assigned with <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (!run || restart || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign tick = run && (r_count == LAST);

endmodule

// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
// Sequencer for the digital_clock counter. Generates the 1 s count-enable
// tick, and runs a time-set FSM from two debounced pushbuttons: mode captures
// the running time into shadow registers and steps hours -> minutes ->
// seconds -> back to run (loading the edited time); inc steps the field under
// edit with wrap and no carry. The field being edited blinks.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   mode_btn  in   debounced level; rising edge advances the FSM
//   inc_btn   in   debounced level; rising edge increments the edited field
//   cur_h/m/s in   running time from the counter
//   en        out  one-cycle count tick, only in RUN
//   load      out  one-cycle pulse: counter takes load_h/m/s
//   load_h/m/s out shadow time
//   field     out  0 none, 1 hour, 2 minute, 3 second
//   blink     out  edit-field blink phase, 0 in RUN
// -----------------------------------------------------------------------------
module clock_set_controller
   import clock_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 100000000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode_btn,
   input  logic              inc_btn,
   input  logic [HOUR_W-1:0] cur_h,
   input  logic [MIN_W-1:0]  cur_m,
   input  logic [SEC_W-1:0]  cur_s,
   output logic              en,
   output logic              load,
   output logic [HOUR_W-1:0] load_h,
   output logic [MIN_W-1:0]  load_m,
   output logic [SEC_W-1:0]  load_s,
   output logic [1:0]        field,
   output logic              blink
);

   state_t            r_state;
   logic              r_mode_d1, r_mode_d2;
   logic              r_inc_d1, r_inc_d2;
   logic [1:0]        r_hist_vld;
   logic              r_load;
   logic [HOUR_W-1:0] r_load_h;
   logic [MIN_W-1:0]  r_load_m;
   logic [SEC_W-1:0]  r_load_s;
   logic [1:0]        r_field;
   logic              r_blink;

   logic              w_mode_press, w_inc_press;
   logic              w_run, w_blink_restart;
   logic              w_en_tick, w_blink_tick;

   // Button history. r_hist_vld marks when the older history bit holds a real
   // post-reset sample, so a button held through reset release is not seen
   // as a fresh press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mode_d1  <= 1'b0;
         r_mode_d2  <= 1'b0;
         r_inc_d1   <= 1'b0;
         r_inc_d2   <= 1'b0;
         r_hist_vld <= 2'b00;
      end else begin
         r_mode_d1  <= mode_btn;
         r_mode_d2  <= r_mode_d1;
         r_inc_d1   <= inc_btn;
         r_inc_d2   <= r_inc_d1;
         r_hist_vld <= {r_hist_vld[0], 1'b1};
      end
   end

   // mode takes priority: an inc in the same cycle as mode is dropped here,
   // so the FSM never has to arbitrate.
   assign w_mode_press    = r_hist_vld[1] & r_mode_d1 & ~r_mode_d2;
   assign w_inc_press     = r_hist_vld[1] & r_inc_d1 & ~r_inc_d2 & ~w_mode_press;
   assign w_run           = (r_state == RUN);
   assign w_blink_restart = w_mode_press | w_inc_press;

   tick_prescaler #(.DIV(TICK_DIV)) u_en_prescaler (
      .clk     (clk),
      .rst     (rst),
      .run     (w_run),
      .restart (1'b0),
      .tick    (w_en_tick)
   );

   tick_prescaler #(.DIV(BLINK_DIV)) u_blink_prescaler (
      .clk     (clk),
      .rst     (rst),
      .run     (~w_run),
      .restart (w_blink_restart),
      .tick    (w_blink_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= RUN;
         r_field  <= FIELD_NONE;
         r_load   <= 1'b0;
         r_load_h <= '0;
         r_load_m <= '0;
         r_load_s <= '0;
         r_blink  <= 1'b0;
      end else begin
         r_load <= 1'b0;
         // Blink tick only fires in SET states; a press below overrides it
         // and restarts the phase at 1.
         if (w_blink_tick) begin
            r_blink <= ~r_blink;
         end
         unique case (r_state)
            RUN: begin
               if (w_mode_press) begin
                  r_state  <= SET_H;
                  r_field  <= FIELD_HOUR;
                  r_blink  <= 1'b1;
                  r_load_h <= cur_h;
                  r_load_m <= cur_m;
                  r_load_s <= cur_s;
               end
            end
            SET_H: begin
               if (w_mode_press) begin
                  r_state <= SET_M;
                  r_field <= FIELD_MIN;
                  r_blink <= 1'b1;
               end else if (w_inc_press) begin
                  r_load_h <= HOUR_W'(wrap_inc(6'(r_load_h), 6'(MAX_HOUR)));
                  r_blink  <= 1'b1;
               end
            end
            SET_M: begin
               if (w_mode_press) begin
                  r_state <= SET_S;
                  r_field <= FIELD_SEC;
                  r_blink <= 1'b1;
               end else if (w_inc_press) begin
                  r_load_m <= wrap_inc(r_load_m, 6'(MAX_MIN));
                  r_blink  <= 1'b1;
               end
            end
            SET_S: begin
               if (w_mode_press) begin
                  r_state <= RUN;
                  r_field <= FIELD_NONE;
                  r_blink <= 1'b0;
                  r_load  <= 1'b1;
               end else if (w_inc_press) begin
                  r_load_s <= wrap_inc(r_load_s, 6'(MAX_SEC));
                  r_blink  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign en     = w_en_tick;
   assign load   = r_load;
   assign load_h = r_load_h;
   assign load_m = r_load_m;
   assign load_s = r_load_s;
   assign field  = r_field;
   assign blink  = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
// Directed scenarios followed by a randomized phase. A behavioural model
// tracks the controller in terms of "which field is being edited", the shadow
// time, cycles spent in RUN and cycles since the blink phase last restarted;
// every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_clock_set_controller;

   localparam int TICK_DIV  = 4;
   localparam int BLINK_DIV = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_btn, inc_btn;
   logic [4:0] cur_h;
   logic [5:0] cur_m, cur_s;
   logic       en, load;
   logic [4:0] load_h;
   logic [5:0] load_m, load_s;
   logic [1:0] field;
   logic       blink;

   int n_checks = 0;
   int n_errors = 0;

   int step_no       = 0;
   int en_seen       = 0;
   int load_seen     = 0;
   int first_en_step = -1;
   int load_step     = -1;
   int en_after_load = -1;
   int base_step     = 0;

   // Model state
   int m_field, m_h, m_m, m_s;
   int m_run_age;    // cycles since the prescaler last sat at count 0
   int m_blink_age;  // cycles since the blink phase last restarted
   bit m_load;
   bit m_ev_mode, m_ev_inc;         // press seen at previous edge, acts now
   bit m_last_mode, m_last_inc, m_last_valid;

   clock_set_controller #(
      .TICK_DIV  (TICK_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_btn (mode_btn),
      .inc_btn  (inc_btn),
      .cur_h    (cur_h),
      .cur_m    (cur_m),
      .cur_s    (cur_s),
      .en       (en),
      .load     (load),
      .load_h   (load_h),
      .load_m   (load_m),
      .load_s   (load_s),
      .field    (field),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d (step %0d)", tag, obs, exp, step_no);
      end
   endtask

   // Advance the model across one rising edge using the inputs sampled there.
   task automatic model_edge();
      if (!rst) begin
         m_field = 0; m_h = 0; m_m = 0; m_s = 0;
         m_run_age = 0; m_blink_age = 0; m_load = 0;
         m_ev_mode = 0; m_ev_inc = 0;
         m_last_mode = 0; m_last_inc = 0; m_last_valid = 0;
         return;
      end
      m_load = 0;
      if (m_field == 0) begin
         m_run_age++;
         if (m_ev_mode) begin
            m_field = 1;
            m_h = int'(cur_h); m_m = int'(cur_m); m_s = int'(cur_s);
            m_blink_age = 0;
         end
      end else if (m_ev_mode) begin
         if (m_field == 3) begin
            m_field = 0; m_load = 1; m_run_age = 0;
         end else begin
            m_field++; m_blink_age = 0;
         end
      end else if (m_ev_inc) begin
         case (m_field)
            1: m_h = (m_h + 1) % 24;
            2: m_m = (m_m + 1) % 60;
            default: m_s = (m_s + 1) % 60;
         endcase
         m_blink_age = 0;
      end else begin
         m_blink_age++;
      end
      m_ev_mode    = m_last_valid && mode_btn && !m_last_mode;
      m_ev_inc     = m_last_valid && inc_btn && !m_last_inc;
      m_last_mode  = mode_btn;
      m_last_inc   = inc_btn;
      m_last_valid = 1;
   endtask

   task automatic check_outputs();
      check("en", en, (m_field == 0) && ((m_run_age % TICK_DIV) == TICK_DIV - 1));
      check("load", load, m_load);
      check("field", field, m_field);
      check("blink", blink, (m_field != 0) && (((m_blink_age / BLINK_DIV) % 2) == 0));
      check("load_h", load_h, m_h);
      check("load_m", load_m, m_m);
      check("load_s", load_s, m_s);
      check("en_load_excl", en & load, 0);
   endtask

   task automatic step(input logic r, input logic m, input logic i);
      @(negedge clk);
      rst = r; mode_btn = m; inc_btn = i;
      @(posedge clk);
      model_edge();
      #1;
      step_no++;
      check_outputs();
      if (en === 1'b1) begin
         en_seen++;
         if (first_en_step < 0) first_en_step = step_no;
         if (load_step >= 0 && en_after_load < 0) en_after_load = step_no;
      end
      if (load === 1'b1) begin
         load_seen++;
         load_step = step_no;
         en_after_load = -1;
      end
   endtask

   // One press: button high for two cycles (one edge only), then released.
   task automatic press(input logic m, input logic i);
      step(1'b1, m, i);
      step(1'b1, m, i);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic rm, ri;
      rst = 1'b0; mode_btn = 1'b1; inc_btn = 1'b0;
      cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;

      // Reset with mode held high throughout.
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
      check("rst_field", field, 0);
      check("rst_en", en, 0);
      check("rst_blink", blink, 0);
      check("rst_load_h", load_h, 0);

      // Idle 20 cycles; mode still held for the first 3 must not count as a press.
      // The release cycle itself is the prescaler's count-0 cycle, so the first
      // en lands TICK_DIV-1 steps after it.
      en_seen = 0; first_en_step = -1; base_step = step_no;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 17; k++) step(1'b1, 1'b0, 1'b0);
      check("idle_en_count", en_seen, 5);
      check("idle_first_en", first_en_step - base_step, TICK_DIV - 1);
      check("held_btn_no_edge", field, 0);

      // Capture 12:34:56 on entering SET_H.
      en_seen = 0;
      press(1'b1, 1'b0);
      check("cap_field", field, 1);
      check("cap_h", load_h, 12);
      check("cap_m", load_m, 34);
      check("cap_s", load_s, 56);

      // Hours to 22, then wrap through 23 -> 0 -> 1.
      for (int k = 0; k < 10; k++) press(1'b0, 1'b1);
      check("hour_22", load_h, 22);
      press(1'b0, 1'b1); check("hour_23", load_h, 23);
      press(1'b0, 1'b1); check("hour_wrap_0", load_h, 0);
      press(1'b0, 1'b1); check("hour_1", load_h, 1);
      check("hour_inc_m_kept", load_m, 34);
      check("hour_inc_s_kept", load_s, 56);
      check("set_no_en", en_seen, 0);

      // Edit to 05:59 then wrap minutes with no carry into hours.
      for (int k = 0; k < 4; k++) press(1'b0, 1'b1);
      check("hour_5", load_h, 5);
      press(1'b1, 1'b0);
      check("field_min", field, 2);
      for (int k = 0; k < 25; k++) press(1'b0, 1'b1);
      check("min_59", load_m, 59);
      press(1'b0, 1'b1);
      check("min_wrap_0", load_m, 0);
      check("min_wrap_h_kept", load_h, 5);
      press(1'b1, 1'b0);
      check("field_sec", field, 3);
      for (int k = 0; k < 4; k++) press(1'b0, 1'b1);
      check("sec_wrap_0", load_s, 0);

      // Fourth mode press: one load pulse of 05:00:00, then en TICK_DIV-1 later.
      load_seen = 0; load_step = -1; en_after_load = -1;
      press(1'b1, 1'b0);
      for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0);
      check("load_pulses", load_seen, 1);
      check("loaded_h", load_h, 5);
      check("loaded_m", load_m, 0);
      check("loaded_s", load_s, 0);
      check("load_to_en", en_after_load - load_step, TICK_DIV - 1);

      // mode and inc together in SET_M: mode wins, minutes untouched.
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      check("both_pre_field", field, 2);
      press(1'b1, 1'b1);
      check("both_field", field, 3);
      check("both_min_kept", load_m, 34);

      // Reset while in SET_S: back to RUN, no load, en resumes on schedule.
      load_seen = 0;
      step(1'b0, 1'b0, 1'b0);
      check("midrst_field", field, 0);
      en_seen = 0; first_en_step = -1; base_step = step_no;
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0);
      check("midrst_no_load", load_seen, 0);
      check("midrst_first_en", first_en_step - base_step, TICK_DIV - 1);
      check("midrst_en_count", en_seen, 3);

      // Randomized phase with occasional resets.
      rm = 1'b0; ri = 1'b0;
      for (int k = 0; k < 500; k++) begin
         cur_h = 5'($urandom_range(0, 23));
         cur_m = 6'($urandom_range(0, 59));
         cur_s = 6'($urandom_range(0, 59));
         if ($urandom_range(0, 11) == 0) rm = ~rm;
         if ($urandom_range(0, 2) == 0) ri = ~ri;
         step(($urandom_range(0, 149) != 0), rm, ri);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
